// File: rtl/bitrev_reorder_if.sv
// Streaming sample bus between the last FFT butterfly stage and the
// bit-reversal reorder buffer, plus the reordered output stream.
interface bitrev_reorder_if #(
  parameter int W = 32
);
  logic           start_ip;
  logic [2*W-1:0] ip;
  logic [2*W-1:0] op;
  logic           start_op;
  logic           valid_op;
  logic           frame_err;

  // Upstream side: drives the bit-reversed stream, observes the reordered one
  modport master (
    output start_ip, ip,
    input  op, start_op, valid_op, frame_err
  );

  // Reorder buffer side
  modport slave (
    input  start_ip, ip,
    output op, start_op, valid_op, frame_err
  );
endinterface

// File: rtl/bitrev_reorder.sv
// Output reorder buffer for the radix-2 SDF FFT. Frames arrive in bit-reversed
// index order and are written to bit-reversed addresses of one ping-pong bank.
// Completed banks are then read out in natural order, so back-to-back frames
// stream out with no gap.
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  bitrev_reorder_if.slave bus
);
  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST = {N{1'b1}};

  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_t;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

  logic [2*W-1:0] mem [2][DEPTH];

  wr_state_t  wr_state, wr_state_next;
  logic [N-1:0] wr_cnt, wr_cnt_next, wr_idx, wr_addr;
  logic       wr_bank, wr_bank_next, wr_en;
  logic       full_next, full_q, full_bank_q;
  logic       err_next, err_pend;

  rd_state_t  rd_state, rd_state_next;
  logic [N-1:0] rd_cnt, rd_cnt_next, rd_addr;
  logic       rd_bank, rd_bank_next, rd_sel, rd_en, rd_first;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  // Write side: a start pulse always (re)begins at index 0; the last index completes the bank
  always_comb begin
    wr_state_next = wr_state;
    wr_cnt_next   = wr_cnt;
    wr_bank_next  = wr_bank;
    wr_en         = 1'b0;
    wr_idx        = wr_cnt;
    full_next     = 1'b0;
    err_next      = 1'b0;
    if (bus.start_ip) begin
      wr_en    = 1'b1;
      wr_idx   = '0;
      err_next = (wr_state == WR_ACTIVE) && (wr_cnt != '0);
    end else if (wr_state == WR_ACTIVE) begin
      wr_en = 1'b1;
    end
    wr_addr = bitrev(wr_idx);
    if (wr_en) begin
      wr_cnt_next = wr_idx + N'(1);
      if (wr_idx == LAST) begin
        full_next     = 1'b1;
        wr_bank_next  = ~wr_bank;
        wr_state_next = WR_IDLE;
      end else begin
        wr_state_next = WR_ACTIVE;
      end
    end
  end

  // Read side: a freshly completed bank takes priority so the next frame follows with no gap
  always_comb begin
    rd_state_next = rd_state;
    rd_cnt_next   = rd_cnt;
    rd_bank_next  = rd_bank;
    rd_en         = 1'b0;
    rd_first      = 1'b0;
    rd_addr       = rd_cnt;
    rd_sel        = rd_bank;
    if (full_q) begin
      rd_en         = 1'b1;
      rd_first      = 1'b1;
      rd_addr       = '0;
      rd_sel        = full_bank_q;
      rd_bank_next  = full_bank_q;
      rd_cnt_next   = N'(1);
      rd_state_next = RD_ACTIVE;
    end else if (rd_state == RD_ACTIVE) begin
      rd_en       = 1'b1;
      rd_cnt_next = rd_cnt + N'(1);
      if (rd_cnt == LAST) rd_state_next = RD_IDLE;
    end
  end

  // Sample storage is deliberately left out of reset; stale contents are never read
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_bank][wr_addr] <= bus.ip;
  end

  // State and output registers; frame_err trails the offending start by one extra cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= WR_IDLE;
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      full_q        <= 1'b0;
      full_bank_q   <= 1'b0;
      err_pend      <= 1'b0;
      rd_state      <= RD_IDLE;
      rd_cnt        <= '0;
      rd_bank       <= 1'b0;
      bus.op        <= '0;
      bus.start_op  <= 1'b0;
      bus.valid_op  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      wr_state      <= wr_state_next;
      wr_cnt        <= wr_cnt_next;
      wr_bank       <= wr_bank_next;
      full_q        <= full_next;
      full_bank_q   <= wr_bank;
      err_pend      <= err_next;
      rd_state      <= rd_state_next;
      rd_cnt        <= rd_cnt_next;
      rd_bank       <= rd_bank_next;
      bus.op        <= rd_en ? mem[rd_sel][rd_addr] : '0;
      bus.start_op  <= rd_first;
      bus.valid_op  <= rd_en;
      bus.frame_err <= err_pend;
    end
  end
endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder: reset, single frame, back-to-back frames,
// mid-frame restart, reset during readout, and a 16-point instance.
module tb_bitrev_reorder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bitrev_reorder_if #(.W(32)) bus3 ();
  bitrev_reorder_if #(.W(32)) bus4 ();

  bitrev_reorder #(.N(3), .W(32)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  bitrev_reorder #(.N(4), .W(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Natural-order output indices map back to these bit-reversed arrival positions
  int exp3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int re, input int im);
    return {re[31:0], im[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkCycle(input string name, input int c,
                            input logic gv, input logic gs, input logic [63:0] gop, input logic ge,
                            input logic ev, input logic es, input logic [63:0] eop, input logic ee);
    checkOutput($sformatf("%s c%0d valid_op", name, c), {63'd0, gv}, {63'd0, ev});
    checkOutput($sformatf("%s c%0d start_op", name, c), {63'd0, gs}, {63'd0, es});
    checkOutput($sformatf("%s c%0d op", name, c), gop, eop);
    checkOutput($sformatf("%s c%0d frame_err", name, c), {63'd0, ge}, {63'd0, ee});
  endtask

  // Drive inputs at the falling edge, then return just after the next rising edge
  task automatic applyStimulus(input logic r, input logic s3, input logic [63:0] d3,
                               input logic s4, input logic [63:0] d4);
    @(negedge clk);
    rst           = r;
    bus3.start_ip = s3;
    bus3.ip       = d3;
    bus4.start_ip = s4;
    bus4.ip       = d4;
    @(posedge clk);
    #1;
  endtask

  // Test sequence
  initial begin
    logic        ev, es, ee;
    logic [63:0] eop;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus3.start_ip = 1'b0;
    bus3.ip = '0;
    bus4.start_ip = 1'b0;
    bus4.ip = '0;

    // Reset held with start_ip high and random data: outputs stay quiet
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, {$urandom, $urandom});
      checkCycle("reset", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, 0, 0, '0, 0);
      checkCycle("reset4", c, bus4.valid_op, bus4.start_op, bus4.op, bus4.frame_err, 0, 0, '0, 0);
    end
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b0, {$urandom, $urandom}, 1'b0, '0);
      checkCycle("post_reset", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, 0, 0, '0, 0);
    end

    // Single frame: real k, imag 100+k; idle-cycle data must be ignored
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1'b0, c == 0, (c < 8) ? mk(c, 100 + c) : {$urandom, $urandom}, 1'b0, '0);
      ev  = (c >= 8) && (c < 16);
      es  = (c == 8);
      eop = ev ? mk(exp3[c-8], 100 + exp3[c-8]) : '0;
      checkCycle("single", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, ev, es, eop, 0);
    end

    // Back-to-back frames: second start_ip immediately after the last sample
    for (int c = 0; c < 26; c++) begin
      applyStimulus(1'b0, (c == 0) || (c == 8), (c < 16) ? mk(c, 100 + c) : '0, 1'b0, '0);
      ev  = (c >= 8) && (c < 24);
      es  = (c == 8) || (c == 16);
      eop = ev ? mk(8 * ((c - 8) / 8) + exp3[(c-8) % 8], 100 + 8 * ((c - 8) / 8) + exp3[(c-8) % 8]) : '0;
      checkCycle("b2b", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, ev, es, eop, 0);
    end

    // Mid-frame restart at cycle 3: partial frame dropped, frame_err after E4
    for (int c = 0; c < 21; c++) begin
      applyStimulus(1'b0, (c == 0) || (c == 3),
                    (c < 3) ? mk(20 + c, 120 + c) : ((c < 11) ? mk(50 + c - 3, 200 + c - 3) : '0),
                    1'b0, '0);
      ev  = (c >= 11) && (c < 19);
      es  = (c == 11);
      ee  = (c == 4);
      eop = ev ? mk(50 + exp3[c-11], 200 + exp3[c-11]) : '0;
      checkCycle("restart", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, ev, es, eop, ee);
    end

    // Reset after three outputs: the rest of the frame is discarded
    for (int c = 0; c < 22; c++) begin
      applyStimulus(c == 11, c == 0, (c < 8) ? mk(30 + c, 130 + c) : '0, 1'b0, '0);
      ev  = (c >= 8) && (c < 11);
      es  = (c == 8);
      eop = ev ? mk(30 + exp3[c-8], 130 + exp3[c-8]) : '0;
      checkCycle("rst_mid", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, ev, es, eop, 0);
    end
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1'b0, c == 0, (c < 8) ? mk(60 + c, 160 + c) : '0, 1'b0, '0);
      ev  = (c >= 8) && (c < 16);
      es  = (c == 8);
      eop = ev ? mk(60 + exp3[c-8], 160 + exp3[c-8]) : '0;
      checkCycle("fresh", c, bus3.valid_op, bus3.start_op, bus3.op, bus3.frame_err, ev, es, eop, 0);
    end

    // 16-point instance
    for (int c = 0; c < 34; c++) begin
      applyStimulus(1'b0, 1'b0, '0, c == 0, (c < 16) ? mk(c, 300 + c) : '0);
      ev  = (c >= 16) && (c < 32);
      es  = (c == 16);
      eop = ev ? mk(exp4[c-16], 300 + exp4[c-16]) : '0;
      checkCycle("n4", c, bus4.valid_op, bus4.start_op, bus4.op, bus4.frame_err, ev, es, eop, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
